// File: rtl/bla_serial_sub_pkg.sv
// rtl/bla_serial_sub_pkg.sv - shared definitions for the nibble-serial subtractor
package bla_serial_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble datapath still gets one bit.
    function automatic int idx_width(input int width);
        int nnib;
        nnib = width / NIBBLE_W;
        return (nnib <= 1) ? 1 : $clog2(nnib);
    endfunction

endpackage

// File: rtl/bla_serial_sub_bla4_slice.sv
// rtl/bla_serial_sub_bla4_slice.sv - combinational 4-bit borrow-lookahead subtractor
module bla4_slice
    import bla_serial_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   br;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Every borrow is a flat sum of products of g, p and bin; nothing ripples.
    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ br[NIBBLE_W-1:0];
    assign bout = br[NIBBLE_W];

endmodule

// File: rtl/bla_serial_sub.sv
// rtl/bla_serial_sub.sv - multi-cycle A - B - BIN, one borrow-lookahead nibble per clock
module bla_serial_sub
    import bla_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NNIB  = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(WIDTH);
    localparam int MSB   = WIDTH - 1;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]    idx;
    logic [IDX_W+1:0]    bit_off;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [WIDTH-1:0]    diff_r;
    logic [WIDTH-1:0]    diff_next;
    logic                br_r;
    logic                bout_r;
    logic                zero_r;
    logic                ovf_r;
    logic                last_step;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_d;
    logic                slice_bout;

    assign bit_off   = {idx, 2'b00};
    assign last_step = (idx == IDX_W'(NNIB - 1));
    assign slice_a   = a_r[bit_off +: NIBBLE_W];
    assign slice_b   = b_r[bit_off +: NIBBLE_W];

    bla4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (br_r),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // Current diff with this step's nibble merged in, so flags see the full result.
    always_comb begin
        diff_next = diff_r;
        diff_next[bit_off +: NIBBLE_W] = slice_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            br_r   <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        br_r   <= bin;
                        idx    <= '0;
                        diff_r <= '0;
                        bout_r <= 1'b0;
                        zero_r <= 1'b0;
                        ovf_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    diff_r <= diff_next;
                    br_r   <= slice_bout;
                    if (last_step) begin
                        idx    <= '0;
                        bout_r <= slice_bout;
                        zero_r <= (diff_next == '0);
                        ovf_r  <= (a_r[MSB] != b_r[MSB]) && (diff_next[MSB] != a_r[MSB]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign diff = diff_r;
    assign bout = bout_r;
    assign zero = zero_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_bla_serial_sub.sv
// tb/tb_bla_serial_sub.sv - directed self-checking bench for bla_serial_sub and bla4_slice
module tb_bla_serial_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    logic [3:0]  sa;
    logic [3:0]  sb;
    logic        sbin;
    logic [3:0]  sd;
    logic        sbo;
    logic [4:0]  exp5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bla_serial_sub #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    bla4_slice u_slice_ref (
        .a    (sa),
        .b    (sb),
        .bin  (sbin),
        .d    (sd),
        .bout (sbo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the first IDLE negedge after done.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] ediff, input logic ebout,
                          input logic ezero, input logic eovf, input int poke);
        int n;
        int busy_cnt;
        bit seen;
        a     = va;
        b     = vb;
        bin   = vbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        bin   = 1'($urandom);
        check({tag, ".busy_first"}, 32'(busy), 1);
        check({tag, ".done_first"}, 32'(done), 0);
        n        = 0;
        busy_cnt = busy ? 1 : 0;
        seen     = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
            end else if (n == poke) begin
                start = 1'b1;
                a     = 16'hA5A5;
                b     = 16'h5A5A;
                bin   = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, n, 4);
        check({tag, ".busy_cycles"}, busy_cnt, 5);
        check({tag, ".diff"}, 32'(diff), 32'(ediff));
        check({tag, ".bout"}, 32'(bout), 32'(ebout));
        check({tag, ".zero"}, 32'(zero), 32'(ezero));
        check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 0);
        check({tag, ".idle"}, 32'(busy), 0);
        check({tag, ".diff_hold"}, 32'(diff), 32'(ediff));
        check({tag, ".bout_hold"}, 32'(bout), 32'(ebout));
        check({tag, ".zero_hold"}, 32'(zero), 32'(ezero));
    endtask

    initial begin
        int  waited;
        bit  stray_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        bin   = 1'b0;
        sa    = 4'h0;
        sb    = 4'h0;
        sbin  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.diff", 32'(diff), 0);
        check("rst.bout", 32'(bout), 0);
        check("rst.zero", 32'(zero), 0);
        check("rst.ovf", 32'(ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("v1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, -1);
        run_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, -1);
        run_op("binin", 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, -1);
        run_op("ovfneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, -1);
        run_op("ovfpos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, -1);
        run_op("eqzero", 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, -1);
        run_op("eqbin", 16'hBEEF, 16'hBEEF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, -1);
        run_op("ignstart", 16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0, 1'b0, 2);
        run_op("b2b", 16'h4000, 16'h4001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, -1);

        a     = 16'hFFFF;
        b     = 16'h0000;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        check("abort.diff", 32'(diff), 0);
        check("abort.bout", 32'(bout), 0);
        check("abort.zero", 32'(zero), 0);
        check("abort.ovf", 32'(ovf), 0);
        stray_done = 1'b0;
        for (waited = 0; waited < 6; waited++) begin
            @(negedge clk);
            if (done || busy) stray_done = 1'b1;
        end
        check("abort.no_done", 32'(stray_done), 0);
        run_op("after_rst", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 512; i++) begin
            {sbin, sa, sb} = 9'(i);
            #1;
            exp5 = {1'b0, sa} - {1'b0, sb} - {4'b0000, sbin};
            check("slice", 32'({sbo, sd}), 32'(exp5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bla_serial_sub.md
Name: bla_serial_sub

Overview:
- Multi-cycle wide subtractor: the subtraction counterpart of the team's 4-bit carry-lookahead adder.
- Computes DIFF = A - B - BIN over WIDTH bits, one 4-bit nibble per clock.
- Each nibble uses a borrow-lookahead slice; the borrow is chained between nibbles through a register.
- Sits beside the adder in the arithmetic datapath; driven by a start/done handshake from a controller.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 4.
- NNIB, WIDTH/4 (derived localparam), number of nibble steps.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result A - B - BIN, modulo 2^WIDTH.
- bout  output  1  final borrow out; 1 means unsigned A < B + BIN.
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset: rst is synchronous and active-high and takes priority over everything.
  - State goes to IDLE.
  - busy, done, diff, bout, zero and ovf all go to 0.
  - Nibble index, borrow register and operand registers are cleared.
  - A reset mid-operation aborts the operation; no done is produced.
  - If start and rst are high on the same edge, rst wins.
- States: IDLE, RUN, DONE.
- IDLE to RUN on an edge with start=1:
  - Latch a and b into shift registers and bin into the borrow register.
  - Clear idx and diff.
  - The a, b and bin inputs are don't-care after this edge.
- RUN step, on each edge:
  - Slice input: nibble idx of the latched a and b, plus the current borrow.
  - Write the slice difference into diff[4*idx+3:4*idx].
  - Register the slice borrow-out.
  - Increment idx.
  - When idx == NNIB-1, go to DONE.
- Latency: done is high in the cycle after the NNIB-th edge following the accepting edge, i.e. NNIB cycles after start was sampled. Example: WIDTH=16 gives 4 cycles.
- DONE, for exactly one cycle:
  - done=1.
  - bout equals the final borrow register.
  - zero and ovf are valid, computed from the full diff.
  - Next edge returns to IDLE.
- Hold: diff, bout, zero and ovf hold their values after done until the next accepted start. They are then cleared or overwritten.
- start is ignored while busy, in both RUN and DONE; there is no queuing. The earliest back-to-back start is the first IDLE cycle after done.
- Slice arithmetic (4-bit borrow lookahead), for i = 0..3:
  - g_i = ~a_i & b_i
  - p_i = ~(a_i ^ b_i)
  - d_i = a_i ^ b_i ^ br_i
  - br_1 = g0 | p0&br0
  - br_2 = g1 | p1&g0 | p1&p0&br0
  - br_3 and br_4 follow the same fully expanded sum-of-products form; no ripple.
  - Slice bout = br_4.
- Wrap-around: results are modulo 2^WIDTH, and bout reports the wrap.
- Edge cases:
  - a == b with bin=0 gives diff=0, zero=1, bout=0.
  - bin=1 with a=b gives all ones and bout=1.
- idx counter width is clog2(NNIB), minimum 1 bit. It never exceeds NNIB-1.

Decomposition:
- Shared arithmetic package:
  - State enum (IDLE, RUN, DONE).
  - NIBBLE_W = 4.
  - A function or constant for the idx width, clog2(WIDTH/4).
- One natural sub-module: bla4_slice.
  - Combinational 4-bit borrow-lookahead subtractor.
  - Ports: a[3:0], b[3:0], bin, d[3:0], bout.
  - Instantiated once and time-multiplexed over the nibbles.
  - Verified standalone exhaustively: 512 input combinations against a - b - bin.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0234, bin=0, start pulse:
  - done is exactly 4 cycles later.
  - diff=0x1000, bout=0, zero=0, ovf=0.
  - busy is high for 5 cycles (4 RUN + 1 DONE).
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
- a=b=0xBEEF, bin=0 -> diff=0x0000, zero=1. Then a=b=0xBEEF, bin=1 -> diff=0xFFFF, bout=1, zero=0.
- Start pulsed again during RUN with different operands:
  - The second start is ignored and the first result completes unchanged.
  - A start issued in the cycle after done is accepted.
- rst asserted two cycles after start:
  - Next cycle all outputs are 0, state is IDLE and no done appears.
  - A new start then completes normally with correct results.
